rfetch_mp: RTL
==============

RFETCH_MP -- requirements
Module: rfetch_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32: register data width in bits.
REQ-002 SHALL have parameter NUM_REGS, default 32: architectural register count (power of two, at least 2).
REQ-003 SHALL have parameter NUM_WB, default 2: number of writeback ports (at least 1).
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 SHALL have port de_valid, input, 1 bit: decode offers de_rf_cword this cycle.
REQ-007 SHALL have port rf_ready, output, 1 bit: fetch accepts de_rf_cword this cycle.
REQ-008 SHALL have port de_rf_cword, input, rvga_cword: decoded instruction, using fields rs1, rs2, rd and regfile_load.
REQ-009 SHALL have port rf_ex_valid, output, 1 bit: rf_ex_cword holds a valid instruction.
REQ-010 SHALL have port ex_ready, input, 1 bit: execute consumes rf_ex_cword this cycle.
REQ-011 SHALL have port rf_ex_cword, output, rvga_cword: instruction with rs1_data and rs2_data filled in.
REQ-012 SHALL have port wb_rf_cword, input, rvga_cword[NUM_WB]: writeback ports, using fields rd, rd_data and regfile_load.
REQ-013 SHALL have port flush, input, 1 bit: squash the output stage and the decode offer.

Function
REQ-014 SHALL define accept as de_valid && rf_ready, and issue as rf_ex_valid && ex_ready.
REQ-015 SHALL hold register file storage of NUM_REGS x XLEN; x0 reads 0 and is never written.
REQ-016 SHALL treat writeback port k as writing when wb_rf_cword[k].regfile_load is 1 and rd != 0; the write commits at the clock edge.
REQ-017 SHALL resolve two or more ports writing the same rd in one cycle by letting the highest-index port win.
REQ-018 SHALL make source data combinational bypass of any same-cycle writing port matching rs (highest index wins), otherwise the register file value; rs = 0 always gives 0.
REQ-019 SHALL keep a scoreboard pending[NUM_REGS]; on accept with regfile_load = 1 and rd != 0, pending[rd] sets.
REQ-020 SHALL clear pending[r] when any port writes r; a simultaneous set and clear of the same r leaves it set.
REQ-021 SHALL flag a hazard when (rs1 is pending and not written this cycle), or (rs2 is pending and not written this cycle), or (rd is pending and not written this cycle, for a WAW hazard); register 0 never hazards.
REQ-022 SHALL compute rf_ready as (!rf_ex_valid || ex_ready) && !hazard && !flush.
REQ-023 SHALL, on accept, load rf_ex_cword with de_rf_cword plus the bypassed rs1_data/rs2_data and set rf_ex_valid, with 1-cycle latency.
REQ-024 SHALL, on issue without accept, clear rf_ex_valid; with neither, rf_ex_cword is held stable.
REQ-025 SHALL, on flush, clear rf_ex_valid at the next edge, accept nothing, and leave pending and the register file unchanged.
REQ-026 SHALL continue to accept register writes during a hazard, a stall or a flush.

Reset
REQ-027 SHALL, while rst_n = 0, drive rf_ex_valid 0, rf_ex_cword 0, every register 0 and every pending bit 0; rf_ready is then 1.
REQ-028 SHALL make the reset asynchronous, so assertion mid-operation discards in-flight state immediately.

Structure
REQ-029 SHALL use rvga_cword and rvga_word from the shared types package, with XLEN, NUM_REGS and NUM_WB defaults in the shared parameter file.
REQ-030 SHALL place the scoreboard (pending vector, set/clear, hazard compare) in one sub-module, rfetch_scoreboard.

Verification
REQ-031 SHALL cover: write x5 = 0xDEADBEEF on port 0, then accept rs1 = 5 -> rf_ex_cword.rs1_data = 0xDEADBEEF after 1 cycle.
REQ-032 SHALL cover: accept rd = 7 with load, next offer rs2 = 7 -> rf_ready = 0 until port 1 writes x7 = 0x12; that cycle accept with rs2_data = 0x12 (bypass).
REQ-033 SHALL cover: port 0 and port 1 both write x3 (0x1, 0x2) in one cycle -> later read of x3 = 0x2.
REQ-034 SHALL cover: write x0 = 0xFFFF_FFFF, accept rd = 0 with load -> x0 reads 0 and pending stays 0.
REQ-035 SHALL cover: rf_ex_valid = 1, ex_ready = 0 for 3 cycles -> rf_ex_cword stable and rf_ready = 0; then flush -> rf_ex_valid = 0 next cycle.
REQ-036 SHALL cover: rst_n dropped asynchronously mid-stall with pending[9] = 1 -> outputs 0 immediately, pending[9] = 0, and rs1 = 9 accepted immediately after release.

Source files
------------

// File: rtl/rfetch_mp_pkg.sv
// rtl/rfetch_mp_pkg.sv - shared types and default sizes for the register-fetch stage
// Purpose: rvga_word / rvga_cword types plus XLEN, NUM_REGS, NUM_WB defaults.
// Ports: none (package).
package rfetch_mp_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int NUM_WB_DEF   = 2;
  localparam int RIDX_W       = $clog2(NUM_REGS_DEF);

  typedef logic [XLEN_DEF-1:0] rvga_word;
  typedef logic [RIDX_W-1:0]   rvga_ridx;

  // Control word carried from decode through fetch to execute and writeback.
  typedef struct packed {
    logic [15:0] op;
    rvga_ridx    rs1;
    rvga_ridx    rs2;
    rvga_ridx    rd;
    logic        regfile_load;
    rvga_word    rs1_data;
    rvga_word    rs2_data;
    rvga_word    rd_data;
  } rvga_cword;

endpackage

// File: rtl/rfetch_scoreboard.sv
// rtl/rfetch_scoreboard.sv - pending-write scoreboard and hazard detect
// Purpose: tracks registers with an in-flight write and flags RAW/WAW hazards.
// Ports: clk, rst_n       - clock, async active-low reset
//        i_set_en/idx     - mark a destination register pending
//        i_wr_mask        - registers written by writeback this cycle
//        i_rs1/i_rs2/i_rd - indices of the offered instruction
//        o_hazard         - offered instruction must wait
module rfetch_scoreboard
  import rfetch_mp_pkg::*;
#(
  parameter int NUM_REGS = NUM_REGS_DEF
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        i_set_en,
  input  logic [$clog2(NUM_REGS)-1:0] i_set_idx,
  input  logic [NUM_REGS-1:0]         i_wr_mask,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs1,
  input  logic [$clog2(NUM_REGS)-1:0] i_rs2,
  input  logic [$clog2(NUM_REGS)-1:0] i_rd,
  output logic                        o_hazard
);

  logic [NUM_REGS-1:0] r_pending;
  logic [NUM_REGS-1:0] w_set_vec;
  logic                w_busy_rs1;
  logic                w_busy_rs2;
  logic                w_busy_rd;

  always_comb begin
    w_set_vec = '0;
    if (i_set_en && (i_set_idx != '0)) begin
      w_set_vec[i_set_idx] = 1'b1;
    end
  end

  // Set is OR-ed after the clear so a same-cycle set and clear leaves the bit set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~i_wr_mask) | w_set_vec;
    end
  end

  // A register being written this cycle is resolved by bypass, so it does not stall.
  always_comb begin
    w_busy_rs1 = (i_rs1 != '0) && r_pending[i_rs1] && !i_wr_mask[i_rs1];
    w_busy_rs2 = (i_rs2 != '0) && r_pending[i_rs2] && !i_wr_mask[i_rs2];
    w_busy_rd  = (i_rd  != '0) && r_pending[i_rd]  && !i_wr_mask[i_rd];
    o_hazard   = w_busy_rs1 || w_busy_rs2 || w_busy_rd;
  end

endmodule

// File: rtl/rfetch_mp.sv
// rtl/rfetch_mp.sv - register-fetch stage with multi-port writeback and bypass
// Purpose: reads rs1/rs2 (with same-cycle writeback bypass), stalls on hazards,
//          and holds one instruction for execute.
// Ports: clk, rst_n            - clock, async active-low reset
//        de_valid/rf_ready     - decode handshake, de_rf_cword offered instruction
//        rf_ex_valid/ex_ready  - execute handshake, rf_ex_cword issued instruction
//        wb_rf_cword[NUM_WB]   - writeback ports (rd, rd_data, regfile_load)
//        flush                 - squash output stage and decode offer
module rfetch_mp
  import rfetch_mp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NUM_REGS = NUM_REGS_DEF,
  parameter int NUM_WB   = NUM_WB_DEF
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      de_valid,
  output logic      rf_ready,
  input  rvga_cword de_rf_cword,
  output logic      rf_ex_valid,
  input  logic      ex_ready,
  output rvga_cword rf_ex_cword,
  input  rvga_cword wb_rf_cword [NUM_WB],
  input  logic      flush
);

  localparam int IDX_W = $clog2(NUM_REGS);

  logic [XLEN-1:0]     r_regs [NUM_REGS];
  logic                r_valid;
  rvga_cword           r_cword;
  logic [NUM_WB-1:0]   w_wr_en;
  logic [NUM_REGS-1:0] w_wr_mask;
  logic [XLEN-1:0]     w_rs1_data;
  logic [XLEN-1:0]     w_rs2_data;
  logic                w_hazard;
  logic                w_accept;
  logic                w_issue;
  logic                w_unused_wb;

  always_comb begin
    w_wr_en   = '0;
    w_wr_mask = '0;
    for (int k = 0; k < NUM_WB; k++) begin
      w_wr_en[k] = wb_rf_cword[k].regfile_load && (wb_rf_cword[k].rd != '0);
      if (w_wr_en[k]) begin
        w_wr_mask[wb_rf_cword[k].rd[IDX_W-1:0]] = 1'b1;
      end
    end
  end

  // Only rd, rd_data and regfile_load of a writeback word matter here.
  always_comb begin
    w_unused_wb = 1'b0;
    for (int k = 0; k < NUM_WB; k++) begin
      w_unused_wb = w_unused_wb ^ (^wb_rf_cword[k]);
    end
  end

  // Later ports override earlier ones, so the highest index wins.
  always_comb begin
    w_rs1_data = r_regs[de_rf_cword.rs1[IDX_W-1:0]];
    w_rs2_data = r_regs[de_rf_cword.rs2[IDX_W-1:0]];
    for (int k = 0; k < NUM_WB; k++) begin
      if (w_wr_en[k] && (wb_rf_cword[k].rd == de_rf_cword.rs1)) begin
        w_rs1_data = wb_rf_cword[k].rd_data;
      end
      if (w_wr_en[k] && (wb_rf_cword[k].rd == de_rf_cword.rs2)) begin
        w_rs2_data = wb_rf_cword[k].rd_data;
      end
    end
    if (de_rf_cword.rs1 == '0) w_rs1_data = '0;
    if (de_rf_cword.rs2 == '0) w_rs2_data = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WB; k++) begin
        if (w_wr_en[k]) begin
          r_regs[wb_rf_cword[k].rd[IDX_W-1:0]] <= wb_rf_cword[k].rd_data;
        end
      end
    end
  end

  rfetch_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_set_en  (w_accept && de_rf_cword.regfile_load),
    .i_set_idx (de_rf_cword.rd[IDX_W-1:0]),
    .i_wr_mask (w_wr_mask),
    .i_rs1     (de_rf_cword.rs1[IDX_W-1:0]),
    .i_rs2     (de_rf_cword.rs2[IDX_W-1:0]),
    .i_rd      (de_rf_cword.rd[IDX_W-1:0]),
    .o_hazard  (w_hazard)
  );

  assign rf_ready = (!r_valid || ex_ready) && !w_hazard && !flush;
  assign w_accept = de_valid && rf_ready;
  assign w_issue  = r_valid && ex_ready;

  // rf_ready already excludes flush, so flush never coincides with accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_cword <= '0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid          <= 1'b1;
      r_cword          <= de_rf_cword;
      r_cword.rs1_data <= w_rs1_data;
      r_cword.rs2_data <= w_rs2_data;
    end else if (w_issue) begin
      r_valid <= 1'b0;
    end
  end

  assign rf_ex_valid = r_valid;
  assign rf_ex_cword = r_cword;

endmodule
